// File: rtl/writeback_port_arbiter_if.sv
// writeback_port_arbiter_if: pipeline, long-latency and register-file write port signals
interface writeback_port_arbiter_if;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_jal;
   logic [31:0] wb_link_addr;
   logic        lr_valid;
   logic        lr_ready;
   logic [4:0]  lr_addr;
   logic [31:0] lr_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        JumpAndLink;
   logic [31:0] link_addr;
   logic [31:0] pending_mask;
   logic        stall_req;
   modport slave (
      input  wb_valid, wb_addr, wb_data, wb_jal, wb_link_addr, lr_valid, lr_addr, lr_data,
      output lr_ready, wr_en, wr_addr, wr_data, JumpAndLink, link_addr, pending_mask, stall_req
   );
   modport master (
      output wb_valid, wb_addr, wb_data, wb_jal, wb_link_addr, lr_valid, lr_addr, lr_data,
      input  lr_ready, wr_en, wr_addr, wr_data, JumpAndLink, link_addr, pending_mask, stall_req
   );
endinterface

// File: rtl/writeback_port_arbiter.sv
// writeback_port_arbiter: merges pipeline writeback and buffered long-latency results onto one write port (optional WB_LR_BYPASS_EN)
module writeback_port_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic                      clk,
   input logic                      rst_n,
   writeback_port_arbiter_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [4:0]       q_addr [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [AW-1:0]    rp, wp;
   logic [CW-1:0]    cnt;
   logic             stall_q;
   logic             full, empty, pipe, jal, push_hs, push, pop, byp, byp_wr;
   logic [31:0]      pm;
   // A ring slot is occupied iff its valid bit is set, so full/empty read straight off the pointers.
   assign full    = vld[wp];
   assign empty   = !vld[rp];
   assign jal     = rst_n && bus.wb_jal;
   assign pipe    = rst_n && (bus.wb_valid || bus.wb_jal);
   assign push_hs = rst_n && bus.lr_valid && !full;
   assign pop     = !pipe && !empty;
`ifdef WB_LR_BYPASS_EN
   assign byp     = push_hs && empty && !pipe;
`else
   assign byp     = 1'b0;
`endif
   assign byp_wr  = byp && bus.lr_addr != 5'd0;
   assign push    = push_hs && bus.lr_addr != 5'd0 && !byp;
   // Write port: jal, then pipeline writeback, then FIFO head, then bypassed result.
   always_comb begin
      bus.lr_ready    = !full;
      bus.wr_en       = pipe || !empty || byp_wr;
      bus.JumpAndLink = jal;
      bus.link_addr   = jal ? bus.wb_link_addr : 32'd0;
      bus.wr_addr     = jal ? 5'd31 : pipe ? bus.wb_addr : !empty ? q_addr[rp] : byp_wr ? bus.lr_addr : 5'd0;
      bus.wr_data     = jal ? bus.wb_link_addr : pipe ? bus.wb_data : !empty ? q_data[rp] : byp_wr ? bus.lr_data : 32'd0;
      bus.stall_req   = stall_q;
   end
   // Pending mask: one bit per register targeted by a buffered entry.
   always_comb begin
      pm = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i]) pm[q_addr[i]] = 1'b1;
      bus.pending_mask = pm;
   end
   // Entry payload storage; contents are only meaningful where vld is set.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wp] <= bus.lr_addr;
         q_data[wp] <= bus.lr_data;
      end
   end
   // Ring pointers and occupancy; push and pop never touch the same slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         rp  <= '0;
         wp  <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         vld <= (vld | ({{(DEPTH-1){1'b0}}, push} << wp)) & ~({{(DEPTH-1){1'b0}}, pop} << rp);
      end
   end
   // Starvation counter: a non-empty FIFO that does not pop is blocked by the pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         stall_q <= 1'b0;
      end else if (pop || empty) begin
         cnt     <= '0;
         stall_q <= 1'b0;
      end else if (cnt != CW'(STARVE_LIMIT)) begin
         cnt     <= cnt + 1'b1;
         stall_q <= cnt == CW'(STARVE_LIMIT - 1);
      end
   end
endmodule
